video_timing_monitor: RTL and testbench

VIDEO_TIMING_MONITOR -- requirements
Module: video_timing_monitor

---
 rtl/vtm_pkg.sv | 14 +
 rtl/vtm_crc16.sv | 26 ++
 rtl/video_timing_monitor.sv | 195 +++++++++++++++++++
 tb/tb_video_timing_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vtm_pkg.sv
// Shared constants and types for the video timing monitor.
package vtm_pkg;

  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam int          FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    CAND   = 2'd1,
    LOCK   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vtm_crc16.sv
// Combinational CRC-16 step: folds one RGB_W-bit pixel into the running CRC, MSB first.
module vtm_crc16
  import vtm_pkg::*;
#(
  parameter int RGB_W = 8
) (
  input  logic [15:0]      crc_in,
  input  logic [RGB_W-1:0] data,
  output logic [15:0]      crc_out
);

  logic [15:0] crc_v;

  always_comb begin
    crc_v = crc_in;
    for (int i = RGB_W - 1; i >= 0; i--) begin
      if (crc_v[15] ^ data[i]) begin
        crc_v = {crc_v[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_v = {crc_v[14:0], 1'b0};
      end
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/video_timing_monitor.sv
// Measures line/frame timing from hsync/vsync/pix_en and tracks timing lock.
// Optional per-frame pixel CRC enabled by defining VIDEO_TIMING_MONITOR_CRC_EN.
module video_timing_monitor
  import vtm_pkg::*;
#(
  parameter int RGB_W    = 8,
  parameter int HCNT_W   = 11,
  parameter int VCNT_W   = 10,
  parameter int SYNC_POL = 0
) (
  input  logic                   clk12m,
  input  logic                   reset,
  input  logic                   pix_en,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [RGB_W-1:0]       rgb,
  output logic [HCNT_W-1:0]      h_total,
  output logic [VCNT_W-1:0]      v_total,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   frame_done,
  output logic                   frame_valid,
  output logic                   locked,
  output logic                   ovf_err,
  output logic [15:0]            frame_crc
);

  localparam logic              SYNC_ACT = (SYNC_POL != 0);
  localparam logic [HCNT_W-1:0] H_MAX    = '1;
  localparam logic [VCNT_W-1:0] V_MAX    = '1;

  logic hs_p0_q, hs_p0_d, vs_p0_q, vs_p0_d;
  logic hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic hedge_q, hedge_d, vedge_q, vedge_d;

  logic [HCNT_W-1:0]      h_cnt_q, h_cnt_d, h_meas_q, h_meas_d;
  logic [VCNT_W-1:0]      v_cnt_q, v_cnt_d, v_inc;
  logic [HCNT_W-1:0]      h_total_q, h_total_d;
  logic [VCNT_W-1:0]      v_total_q, v_total_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic                   armed_q, armed_d;
  logic                   sat_frame_q, sat_frame_d;
  logic                   ovf_q, ovf_d;
  logic                   h_ovf, v_ovf, frame_sat, match;
  lock_state_e            state_q, state_d;

  always_comb begin
    // Stage 0: input register; stage 1: previous level; stage 2: registered leading edge
    hs_p0_d = hsync;
    vs_p0_d = vsync;
    hs_p1_d = hs_p0_q;
    vs_p1_d = vs_p0_q;
    hedge_d = (hs_p0_q == SYNC_ACT) && (hs_p1_q != SYNC_ACT);
    vedge_d = (vs_p0_q == SYNC_ACT) && (vs_p1_q != SYNC_ACT);
  end

  always_comb begin
    h_ovf    = 1'b0;
    v_ovf    = 1'b0;
    h_cnt_d  = h_cnt_q;
    h_meas_d = h_meas_q;
    v_inc    = v_cnt_q;

    // A pixel arriving with the hsync edge belongs to the new line
    if (hedge_q) begin
      h_meas_d = h_cnt_q;
      h_cnt_d  = HCNT_W'(pix_en);
    end else if (pix_en) begin
      if (h_cnt_q == H_MAX) h_ovf = 1'b1;
      else                  h_cnt_d = h_cnt_q + HCNT_W'(1);
    end

    if (hedge_q) begin
      if (v_cnt_q == V_MAX) v_ovf = 1'b1;
      else                  v_inc = v_cnt_q + VCNT_W'(1);
    end
    v_cnt_d = vedge_q ? '0 : v_inc;

    frame_sat   = sat_frame_q | h_ovf | v_ovf;
    sat_frame_d = vedge_q ? 1'b0 : frame_sat;
    ovf_d       = ovf_q | h_ovf | v_ovf;
    armed_d     = armed_q | vedge_q;
    done_d      = vedge_q & armed_q;
    match       = (h_meas_d == h_total_q) && (v_inc == v_total_q);

    h_total_d   = h_total_q;
    v_total_d   = v_total_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = valid_q;
    state_d     = state_q;
    if (done_d) begin
      h_total_d   = h_meas_d;
      v_total_d   = v_inc;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      valid_d     = 1'b1;
      if (frame_sat) begin
        state_d = UNLOCK;
      end else begin
        unique case (state_q)
          UNLOCK:  state_d = CAND;
          CAND:    state_d = match ? LOCK : CAND;
          LOCK:    state_d = match ? LOCK : CAND;
          default: state_d = UNLOCK;
        endcase
      end
    end
  end

  always_ff @(posedge clk12m) begin
    if (reset) begin
      hs_p0_q     <= ~SYNC_ACT;
      vs_p0_q     <= ~SYNC_ACT;
      hs_p1_q     <= ~SYNC_ACT;
      vs_p1_q     <= ~SYNC_ACT;
      hedge_q     <= 1'b0;
      vedge_q     <= 1'b0;
      h_cnt_q     <= '0;
      h_meas_q    <= '0;
      v_cnt_q     <= '0;
      h_total_q   <= '0;
      v_total_q   <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
      sat_frame_q <= 1'b0;
      ovf_q       <= 1'b0;
      state_q     <= UNLOCK;
    end else begin
      hs_p0_q     <= hs_p0_d;
      vs_p0_q     <= vs_p0_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      hedge_q     <= hedge_d;
      vedge_q     <= vedge_d;
      h_cnt_q     <= h_cnt_d;
      h_meas_q    <= h_meas_d;
      v_cnt_q     <= v_cnt_d;
      h_total_q   <= h_total_d;
      v_total_q   <= v_total_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
      sat_frame_q <= sat_frame_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
    end
  end

  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_done  = done_q;
  assign frame_valid = valid_q;
  assign locked      = (state_q == LOCK);
  assign ovf_err     = ovf_q;

`ifdef VIDEO_TIMING_MONITOR_CRC_EN
  logic [15:0] crc_q, crc_d, crc_step, frame_crc_q, frame_crc_d;
  logic        fold;

  vtm_crc16 #(.RGB_W(RGB_W)) u_crc (
    .crc_in (crc_q),
    .data   (rgb),
    .crc_out(crc_step)
  );

  always_comb begin
    fold        = pix_en && (hs_p0_q != SYNC_ACT) && (vs_p0_q != SYNC_ACT);
    crc_d       = crc_q;
    if (vedge_q)   crc_d = CRC_INIT;
    else if (fold) crc_d = crc_step;
    frame_crc_d = done_d ? crc_q : frame_crc_q;
  end

  always_ff @(posedge clk12m) begin
    if (reset) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor: a default instance plus a 4-bit line counter instance.
module tb_video_timing_monitor;

  logic       clk12m = 1'b0;
  logic       reset  = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync  = 1'b1;
  logic       vsync  = 1'b1;
  logic [7:0] rgb    = 8'h00;

  logic [10:0] a_h_total;
  logic [9:0]  a_v_total;
  logic [15:0] a_frame_cnt, a_frame_crc;
  logic        a_frame_done, a_frame_valid, a_locked, a_ovf_err;

  logic [3:0]  b_h_total;
  logic [9:0]  b_v_total;
  logic [15:0] b_frame_cnt, b_frame_crc;
  logic        b_frame_done, b_frame_valid, b_locked, b_ovf_err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always #5 clk12m = ~clk12m;

  video_timing_monitor #(.RGB_W(8), .HCNT_W(11), .VCNT_W(10), .SYNC_POL(0)) dut_a (
    .clk12m(clk12m), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(a_h_total), .v_total(a_v_total), .frame_cnt(a_frame_cnt), .frame_done(a_frame_done),
    .frame_valid(a_frame_valid), .locked(a_locked), .ovf_err(a_ovf_err), .frame_crc(a_frame_crc)
  );

  video_timing_monitor #(.RGB_W(8), .HCNT_W(4), .VCNT_W(10), .SYNC_POL(0)) dut_b (
    .clk12m(clk12m), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .h_total(b_h_total), .v_total(b_v_total), .frame_cnt(b_frame_cnt), .frame_done(b_frame_done),
    .frame_valid(b_frame_valid), .locked(b_locked), .ovf_err(b_ovf_err), .frame_crc(b_frame_crc)
  );

  always @(negedge clk12m) if (a_frame_done) done_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk12m);
      #1;
    end
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      tick();
    end
    tick(2);
  endtask

  task automatic sync_pulse(input bit h, input bit v);
    hsync = h ? 1'b0 : 1'b1;
    vsync = v ? 1'b0 : 1'b1;
    tick(3);
    hsync = 1'b1;
    vsync = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input int npix, input int nlines, input bit coincide);
    for (int l = 0; l < nlines; l++) begin
      pixels(npix);
      if (coincide && l == nlines - 1) sync_pulse(1'b1, 1'b1);
      else                             sync_pulse(1'b1, 1'b0);
    end
    if (!coincide) sync_pulse(1'b0, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++;
    if ({a_h_total, a_v_total, a_frame_cnt, a_frame_done, a_frame_valid, a_locked, a_ovf_err, a_frame_crc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs h=%0d v=%0d cnt=%0d done=%0b valid=%0b lock=%0b ovf=%0b crc=%h expected all 0",
               a_h_total, a_v_total, a_frame_cnt, a_frame_done, a_frame_valid, a_locked, a_ovf_err, a_frame_crc);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    sync_pulse(1'b0, 1'b1);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL arm_no_done got %0d expected 0", done_cnt); end
    send_frame(10, 4, 1'b0);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL first_done got %0d expected 1", done_cnt); end
    checks++;
    if (a_h_total !== 11'd10) begin errors++; $display("FAIL basic_h_total got %0d expected 10", a_h_total); end
    checks++;
    if (a_v_total !== 10'd4) begin errors++; $display("FAIL basic_v_total got %0d expected 4", a_v_total); end
    checks++;
    if (a_frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d expected 1", a_frame_cnt); end
    checks++;
    if (a_frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b expected 1", a_frame_valid); end
    checks++;
    if (a_locked !== 1'b0) begin errors++; $display("FAIL basic_unlocked got %0b expected 0", a_locked); end
    send_frame(10, 4, 1'b0);
    checks++;
    if (a_locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %0b expected 1", a_locked); end
    checks++;
    if (a_frame_cnt !== 16'd2) begin errors++; $display("FAIL basic_frame_cnt2 got %0d expected 2", a_frame_cnt); end
    checks++;
    if (b_h_total !== 4'd10 || b_locked !== 1'b1) begin
      errors++; $display("FAIL b_basic got h=%0d lock=%0b expected h=10 lock=1", b_h_total, b_locked);
    end
  endtask

  task automatic test_relock;
    send_frame(11, 4, 1'b0);
    checks++;
    if (a_h_total !== 11'd11) begin errors++; $display("FAIL relock_h11 got %0d expected 11", a_h_total); end
    checks++;
    if (a_locked !== 1'b0) begin errors++; $display("FAIL relock_drop got %0b expected 0", a_locked); end
    send_frame(10, 4, 1'b0);
    checks++;
    if (a_locked !== 1'b0) begin errors++; $display("FAIL relock_cand got %0b expected 0", a_locked); end
    send_frame(10, 4, 1'b0);
    checks++;
    if (a_locked !== 1'b1) begin errors++; $display("FAIL relock_again got %0b expected 1", a_locked); end
    checks++;
    if (b_locked !== 1'b1 || b_ovf_err !== 1'b0) begin
      errors++; $display("FAIL b_pre_sat got lock=%0b ovf=%0b expected lock=1 ovf=0", b_locked, b_ovf_err);
    end
  endtask

  task automatic test_saturation;
    send_frame(20, 4, 1'b0);
    checks++;
    if (b_h_total !== 4'd15) begin errors++; $display("FAIL sat_h_total got %0d expected 15", b_h_total); end
    checks++;
    if (b_v_total !== 10'd4) begin errors++; $display("FAIL sat_v_total got %0d expected 4", b_v_total); end
    checks++;
    if (b_ovf_err !== 1'b1) begin errors++; $display("FAIL sat_ovf got %0b expected 1", b_ovf_err); end
    checks++;
    if (b_locked !== 1'b0) begin errors++; $display("FAIL sat_unlock got %0b expected 0", b_locked); end
    checks++;
    if (a_h_total !== 11'd20 || a_ovf_err !== 1'b0 || a_locked !== 1'b0) begin
      errors++; $display("FAIL wide_20 got h=%0d ovf=%0b lock=%0b expected h=20 ovf=0 lock=0",
                         a_h_total, a_ovf_err, a_locked);
    end
    send_frame(10, 4, 1'b0);
    checks++;
    if (b_ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b expected 1", b_ovf_err); end
  endtask

  task automatic test_reset_midframe;
    int d0;
    pixels(10);
    sync_pulse(1'b1, 1'b0);
    pixels(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({a_h_total, a_v_total, a_frame_cnt, a_frame_done, a_frame_valid, a_locked, a_ovf_err, a_frame_crc} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs h=%0d v=%0d cnt=%0d valid=%0b lock=%0b expected all 0",
               a_h_total, a_v_total, a_frame_cnt, a_frame_valid, a_locked);
    end
    checks++;
    if (b_ovf_err !== 1'b0) begin errors++; $display("FAIL midreset_ovf got %0b expected 0", b_ovf_err); end
    d0 = done_cnt;
    sync_pulse(1'b0, 1'b1);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL midreset_arm got %0d expected %0d", done_cnt, d0); end
    send_frame(10, 4, 1'b0);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL midreset_done got %0d expected %0d", done_cnt, d0 + 1); end
    checks++;
    if (a_frame_cnt !== 16'd1 || a_h_total !== 11'd10 || a_v_total !== 10'd4) begin
      errors++; $display("FAIL midreset_frame got cnt=%0d h=%0d v=%0d expected cnt=1 h=10 v=4",
                         a_frame_cnt, a_h_total, a_v_total);
    end
  endtask

  task automatic test_coincident;
    send_frame(10, 5, 1'b1);
    checks++;
    if (a_v_total !== 10'd5) begin errors++; $display("FAIL coinc_v_total got %0d expected 5", a_v_total); end
    checks++;
    if (a_h_total !== 11'd10 || a_frame_cnt !== 16'd2) begin
      errors++; $display("FAIL coinc_h_cnt got h=%0d cnt=%0d expected h=10 cnt=2", a_h_total, a_frame_cnt);
    end
    send_frame(10, 4, 1'b0);
    checks++;
    if (a_v_total !== 10'd4) begin errors++; $display("FAIL coinc_next_v got %0d expected 4", a_v_total); end
  endtask

  task automatic test_crc;
    logic [15:0] exp_crc;
    for (int i = 0; i < 9; i++) begin
      rgb    = 8'h31 + 8'(i);
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      tick();
    end
    rgb = 8'h00;
    tick(2);
    sync_pulse(1'b0, 1'b1);
`ifdef VIDEO_TIMING_MONITOR_CRC_EN
    exp_crc = 16'h29B1;
`else
    exp_crc = 16'h0000;
`endif
    checks++;
    if (a_frame_crc !== exp_crc) begin errors++; $display("FAIL crc_check got %h expected %h", a_frame_crc, exp_crc); end
    checks++;
    if (a_frame_cnt !== 16'd4 || a_v_total !== 10'd0) begin
      errors++; $display("FAIL crc_frame got cnt=%0d v=%0d expected cnt=4 v=0", a_frame_cnt, a_v_total);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relock();
    test_saturation();
    test_reset_midframe();
    test_coincident();
    test_crc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
